multicycle_ctrl: RTL and testbench

- Multi-cycle RV32I control FSM; drives the ALU's 3-bit operation select and consumes its 1-bit compare flag (EQ).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Issues write enables for PC, IR, register file and data memory; handles a ready-based memory handshake.

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/ctrl_decoder.sv | 104 ++++++++++
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller:
// FSM states, ALU operation codes, instruction classes, opcodes and immediate selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    ILLEGAL = 3'd5
  } state_t;

  // EQ/LTU/GEU all report their result through the ALU's single compare flag
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_EQ  = 3'b101,
    ALU_LTU = 3'b110,
    ALU_GEU = 3'b111
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct3 codes shared by the register and immediate forms of ADD/XOR/OR/AND
  function automatic logic arith_f3_ok(input logic [2:0] funct3);
    return (funct3 == F3_ADD) || (funct3 == F3_XOR) ||
           (funct3 == F3_OR)  || (funct3 == F3_AND);
  endfunction

  function automatic alu_ctrl_t arith_op(input logic [2:0] funct3);
    alu_ctrl_t op;
    case (funct3)
      F3_XOR:  op = ALU_XOR;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 to instruction class,
// ALU operation, immediate select, ALU operand select, branch polarity and legality.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t cls,
  output alu_ctrl_t    alu_ctrl,
  output logic [1:0]   imm_src,
  output logic         alu_src,
  output logic         branch_invert,
  output logic         legal
);

  always_comb begin
    cls           = CLS_NOP;
    alu_ctrl      = ALU_ADD;
    imm_src       = IMM_I;
    alu_src       = 1'b0;
    branch_invert = 1'b0;
    legal         = 1'b0;

    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE && arith_f3_ok(funct3)) begin
          cls      = CLS_ALU;
          alu_ctrl = arith_op(funct3);
          legal    = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          cls      = CLS_ALU;
          alu_ctrl = ALU_SUB;
          legal    = 1'b1;
        end
      end

      OP_I: begin
        if (arith_f3_ok(funct3)) begin
          cls      = CLS_ALU;
          alu_ctrl = arith_op(funct3);
          alu_src  = 1'b1;
          imm_src  = IMM_I;
          legal    = 1'b1;
        end
      end

      OP_LOAD: begin
        if (funct3 == F3_WORD) begin
          cls      = CLS_LOAD;
          alu_ctrl = ALU_ADD;
          alu_src  = 1'b1;
          imm_src  = IMM_I;
          legal    = 1'b1;
        end
      end

      OP_STORE: begin
        if (funct3 == F3_WORD) begin
          cls      = CLS_STORE;
          alu_ctrl = ALU_ADD;
          alu_src  = 1'b1;
          imm_src  = IMM_S;
          legal    = 1'b1;
        end
      end

      // The ALU only compares unsigned, so signed BLT/BGE stay illegal
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ: begin
            cls      = CLS_BRANCH;
            alu_ctrl = ALU_EQ;
            imm_src  = IMM_B;
            legal    = 1'b1;
          end
          F3_BNE: begin
            cls           = CLS_BRANCH;
            alu_ctrl      = ALU_EQ;
            imm_src       = IMM_B;
            branch_invert = 1'b1;
            legal         = 1'b1;
          end
          F3_BLTU: begin
            cls      = CLS_BRANCH;
            alu_ctrl = ALU_LTU;
            imm_src  = IMM_B;
            legal    = 1'b1;
          end
          F3_BGEU: begin
            cls      = CLS_BRANCH;
            alu_ctrl = ALU_GEU;
            imm_src  = IMM_B;
            legal    = 1'b1;
          end
          default: ;
        endcase
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with a ready-based memory handshake.
// Build macro CTRL_ILLEGAL_TRAP_EN: unsupported instructions park in ILLEGAL; otherwise they retire as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_src,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic                  reg_we,
  output logic                  result_src,
  output logic                  alu_src,
  output logic [1:0]            imm_src,
  output logic [2:0]            ALUctrl,
  output logic                  illegal
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] ir;

  instr_class_t dec_cls;
  alu_ctrl_t    dec_alu;
  logic [1:0]   dec_imm;
  logic         dec_alu_src;
  logic         dec_inv;
  logic         dec_legal;

  instr_class_t cls_q;
  alu_ctrl_t    alu_q;
  logic [1:0]   imm_q;
  logic         alu_src_q;
  logic         inv_q;

  alu_ctrl_t    alu_ctrl;

  // Only opcode/funct3/funct7 steer control; register fields belong to the datapath
  logic unused_ok;
  assign unused_ok = ^{ir[DATA_WIDTH-1:25], ir[24:15], ir[11:7], dec_legal,
                       (RESET_STATE_FETCH != 1)};

  ctrl_decoder u_decoder (
    .opcode        (ir[6:0]),
    .funct3        (ir[14:12]),
    .funct7        (ir[31:25]),
    .cls           (dec_cls),
    .alu_ctrl      (dec_alu),
    .imm_src       (dec_imm),
    .alu_src       (dec_alu_src),
    .branch_invert (dec_inv),
    .legal         (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_we) begin
      ir <= instr;
    end
  end

  // Decode results are frozen in DECODE so EXEC/MEM/WB never see a changing IR decode path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= CLS_NOP;
      alu_q     <= ALU_ADD;
      imm_q     <= IMM_I;
      alu_src_q <= 1'b0;
      inv_q     <= 1'b0;
    end else if (state == DECODE) begin
      cls_q     <= dec_cls;
      alu_q     <= dec_alu;
      imm_q     <= dec_imm;
      alu_src_q <= dec_alu_src;
      inv_q     <= dec_inv;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (state == DECODE && !dec_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Outputs are gated by rst_n so they drop the instant reset asserts, not at the next edge
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    result_src = 1'b0;
    alu_src    = 1'b0;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;

    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we     = 1'b1;
            state_nxt = DECODE;
          end
        end

        DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nxt = dec_legal ? EXEC : ILLEGAL;
`else
          state_nxt = EXEC;
`endif
        end

        EXEC: begin
          alu_ctrl = alu_q;
          alu_src  = alu_src_q;
          imm_src  = imm_q;
          case (cls_q)
            CLS_ALU:              state_nxt = WB;
            CLS_LOAD, CLS_STORE:  state_nxt = MEM;
            CLS_BRANCH: begin
              pc_we     = 1'b1;
              pc_src    = EQ ^ inv_q;
              state_nxt = FETCH;
            end
            default: begin
              pc_we     = 1'b1;
              state_nxt = FETCH;
            end
          endcase
        end

        MEM: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
          mem_we   = (cls_q == CLS_STORE);
          alu_src  = 1'b1;
          imm_src  = imm_q;
          alu_ctrl = ALU_ADD;
          if (mem_ready) begin
            if (cls_q == CLS_STORE) begin
              pc_we     = 1'b1;
              state_nxt = FETCH;
            end else begin
              state_nxt = WB;
            end
          end
        end

        WB: begin
          reg_we     = 1'b1;
          result_src = (cls_q == CLS_LOAD);
          pc_we      = 1'b1;
          state_nxt  = FETCH;
        end

        ILLEGAL: state_nxt = ILLEGAL;

        default: state_nxt = FETCH;
      endcase
    end
  end

  assign ALUctrl = alu_ctrl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued
// with each stimulus and popped/compared mid-cycle. Honors CTRL_ILLEGAL_TRAP_EN for the trap case.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        EQ;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_src, ir_we, pc_we, pc_src;
  logic        reg_we, result_src, alu_src, illegal;
  logic [1:0]  imm_src;
  logic [2:0]  ALUctrl;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];
  logic [15:0] maskQ[$];
  string       tagQ[$];

  localparam logic [15:0] B_MREQ   = 16'h8000;
  localparam logic [15:0] B_MWE    = 16'h4000;
  localparam logic [15:0] B_ASRC   = 16'h2000;
  localparam logic [15:0] B_IRWE   = 16'h1000;
  localparam logic [15:0] B_PCWE   = 16'h0800;
  localparam logic [15:0] B_PCSRC  = 16'h0400;
  localparam logic [15:0] B_REGWE  = 16'h0200;
  localparam logic [15:0] B_RSRC   = 16'h0100;
  localparam logic [15:0] B_ALUSRC = 16'h0080;
  localparam logic [15:0] F_IMM    = 16'h0060;
  localparam logic [15:0] F_ALU    = 16'h001C;
  localparam logic [15:0] B_ILL    = 16'h0002;

  localparam logic [15:0] M_CTL  = B_MREQ | B_MWE | B_IRWE | B_PCWE | B_REGWE | B_ILL;
  localparam logic [15:0] M_ALL  = 16'hFFFE;
  localparam logic [15:0] M_F    = M_CTL | B_ASRC;
  localparam logic [15:0] M_D    = M_CTL;
  localparam logic [15:0] M_XALU = M_CTL | F_ALU | B_ALUSRC;
  localparam logic [15:0] M_XBR  = M_CTL | F_ALU | B_PCSRC;
  localparam logic [15:0] M_XMEM = M_CTL | F_ALU | B_ALUSRC | F_IMM;
  localparam logic [15:0] M_MEM  = M_CTL | B_ASRC | F_ALU;
  localparam logic [15:0] M_WB   = M_CTL | B_PCSRC | B_RSRC;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_ORI  = 32'h00516093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BLTU = 32'h0020E463;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_SW   = 32'h0050A423;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_ctrl #(.DATA_WIDTH(32), .RESET_STATE_FETCH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .EQ         (EQ),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_src   (addr_src),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .result_src (result_src),
    .alu_src    (alu_src),
    .imm_src    (imm_src),
    .ALUctrl    (ALUctrl),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] alu3(input logic [2:0] c);
    return {11'd0, c, 2'd0};
  endfunction

  function automatic logic [15:0] immf(input logic [1:0] c);
    return {9'd0, c, 5'd0};
  endfunction

  task automatic applyStimulus(input logic rstn, input logic mr, input logic eq,
                               input logic [31:0] ins, input logic [15:0] exp,
                               input logic [15:0] mask, input string tag);
    rst_n     = rstn;
    mem_ready = mr;
    EQ        = eq;
    instr     = ins;
    expQ.push_back(exp);
    maskQ.push_back(mask);
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput();
    logic [15:0] obs, exp, mask;
    string       tag;
    @(negedge clk);
    obs  = {mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we, result_src,
            alu_src, imm_src, ALUctrl, illegal, 1'b0};
    exp  = expQ.pop_front();
    mask = maskQ.pop_front();
    tag  = tagQ.pop_front();
    checks++;
    assert ((obs & mask) === (exp & mask))
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%04h expected=%04h mask=%04h", tag, obs & mask, exp & mask, mask);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] multicycle_ctrl directed scoreboard run");

    applyStimulus(0, 1, 0, I_ADD, 16'h0000, M_ALL, "reset_a"); checkOutput();
    applyStimulus(0, 1, 0, I_ADD, 16'h0000, M_ALL, "reset_b"); checkOutput();

    applyStimulus(1, 1, 0, I_ADD, B_MREQ | B_IRWE,  M_F,    "add_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_ADD, 16'h0000,         M_D,    "add_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_ADD, alu3(3'b000),     M_XALU, "add_exec");   checkOutput();
    applyStimulus(1, 1, 0, I_ADD, B_REGWE | B_PCWE, M_WB,   "add_wb");     checkOutput();

    applyStimulus(1, 1, 0, I_SUB, B_MREQ | B_IRWE,  M_F,    "sub_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_SUB, 16'h0000,         M_D,    "sub_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_SUB, alu3(3'b001),     M_XALU, "sub_exec");   checkOutput();
    applyStimulus(1, 1, 0, I_SUB, B_REGWE | B_PCWE, M_WB,   "sub_wb");     checkOutput();

    applyStimulus(1, 1, 0, I_ORI, B_MREQ | B_IRWE,  M_F, "ori_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_ORI, 16'h0000,         M_D, "ori_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_ORI, alu3(3'b011) | B_ALUSRC | immf(2'b00), M_XALU | F_IMM, "ori_exec"); checkOutput();
    applyStimulus(1, 1, 0, I_ORI, B_REGWE | B_PCWE, M_WB, "ori_wb");    checkOutput();

    applyStimulus(1, 1, 0, I_BEQ, B_MREQ | B_IRWE, M_F, "beq1_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BEQ, 16'h0000,        M_D, "beq1_decode"); checkOutput();
    applyStimulus(1, 1, 1, I_BEQ, B_PCWE | B_PCSRC | alu3(3'b101), M_XBR, "beq_taken"); checkOutput();
    applyStimulus(1, 1, 0, I_BEQ, B_MREQ | B_IRWE, M_F, "beq0_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BEQ, 16'h0000,        M_D, "beq0_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_BEQ, B_PCWE | alu3(3'b101), M_XBR, "beq_not_taken"); checkOutput();

    applyStimulus(1, 1, 0, I_BNE, B_MREQ | B_IRWE, M_F, "bne1_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BNE, 16'h0000,        M_D, "bne1_decode"); checkOutput();
    applyStimulus(1, 1, 1, I_BNE, B_PCWE | alu3(3'b101), M_XBR, "bne_eq1"); checkOutput();
    applyStimulus(1, 1, 0, I_BNE, B_MREQ | B_IRWE, M_F, "bne0_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BNE, 16'h0000,        M_D, "bne0_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_BNE, B_PCWE | B_PCSRC | alu3(3'b101), M_XBR, "bne_eq0"); checkOutput();

    applyStimulus(1, 1, 0, I_BLTU, B_MREQ | B_IRWE, M_F, "bltu_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BLTU, 16'h0000,        M_D, "bltu_decode"); checkOutput();
    applyStimulus(1, 1, 1, I_BLTU, B_PCWE | B_PCSRC | alu3(3'b110), M_XBR, "bltu_taken"); checkOutput();

    applyStimulus(1, 1, 0, I_LW, B_MREQ | B_IRWE, M_F, "lw_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_LW, 16'h0000,        M_D, "lw_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_LW, alu3(3'b000) | B_ALUSRC | immf(2'b00), M_XMEM, "lw_exec"); checkOutput();
    applyStimulus(1, 0, 0, I_LW, B_MREQ | B_ASRC | alu3(3'b000), M_MEM, "lw_mem_wait1"); checkOutput();
    applyStimulus(1, 0, 0, I_LW, B_MREQ | B_ASRC | alu3(3'b000), M_MEM, "lw_mem_wait2"); checkOutput();
    applyStimulus(1, 0, 0, I_LW, B_MREQ | B_ASRC | alu3(3'b000), M_MEM, "lw_mem_wait3"); checkOutput();
    applyStimulus(1, 1, 0, I_LW, B_MREQ | B_ASRC | alu3(3'b000), M_MEM, "lw_mem_done");  checkOutput();
    applyStimulus(1, 1, 0, I_LW, B_REGWE | B_RSRC | B_PCWE, M_WB, "lw_wb"); checkOutput();

    applyStimulus(1, 1, 0, I_SW, B_MREQ | B_IRWE, M_F, "sw_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_SW, 16'h0000,        M_D, "sw_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_SW, alu3(3'b000) | B_ALUSRC | immf(2'b01), M_XMEM, "sw_exec"); checkOutput();
    applyStimulus(1, 0, 0, I_SW, B_MREQ | B_ASRC | B_MWE | alu3(3'b000), M_MEM, "sw_mem_wait"); checkOutput();
    applyStimulus(0, 0, 0, I_SW, 16'h0000, M_ALL, "sw_mem_async_reset"); checkOutput();
    applyStimulus(1, 0, 0, I_SW, B_MREQ, M_F, "post_reset_fetch_a"); checkOutput();
    applyStimulus(1, 0, 0, I_SW, B_MREQ, M_F, "post_reset_fetch_b"); checkOutput();
    applyStimulus(1, 1, 0, I_SW, B_MREQ | B_IRWE, M_F, "sw2_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_SW, 16'h0000,        M_D, "sw2_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_SW, alu3(3'b000) | B_ALUSRC | immf(2'b01), M_XMEM, "sw2_exec"); checkOutput();
    applyStimulus(1, 1, 0, I_SW, B_MREQ | B_ASRC | B_MWE | B_PCWE | alu3(3'b000), M_MEM | B_PCSRC, "sw2_mem_retire"); checkOutput();

    applyStimulus(1, 1, 0, I_BAD, B_MREQ | B_IRWE, M_F, "bad_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_BAD, 16'h0000,        M_D, "bad_decode"); checkOutput();
`ifdef CTRL_ILLEGAL_TRAP_EN
    applyStimulus(1, 1, 0, I_ADD, B_ILL, M_ALL, "trap_hold_a"); checkOutput();
    applyStimulus(1, 1, 0, I_ADD, B_ILL, M_ALL, "trap_hold_b"); checkOutput();
    applyStimulus(1, 1, 0, I_ADD, B_ILL, M_ALL, "trap_hold_c"); checkOutput();
`else
    applyStimulus(1, 1, 0, I_BAD, B_PCWE, M_D | B_PCSRC, "bad_nop_retire"); checkOutput();
    applyStimulus(1, 1, 0, I_ADD, B_MREQ | B_IRWE,  M_F,    "after_nop_fetch");  checkOutput();
    applyStimulus(1, 1, 0, I_ADD, 16'h0000,         M_D,    "after_nop_decode"); checkOutput();
    applyStimulus(1, 1, 0, I_ADD, alu3(3'b000),     M_XALU, "after_nop_exec");   checkOutput();
    applyStimulus(1, 1, 0, I_ADD, B_REGWE | B_PCWE, M_WB,   "after_nop_wb");     checkOutput();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
